seq_reader: RTL and testbench

//  Playback side of the sequence register. Takes a snapshot of the N-bit

---
 rtl/seq_reader.sv | 135 +++++++++++++
 tb/tb_seq_reader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_reader.sv
// rtl/seq_reader.sv - snapshot playback of a 4-bit LED sequence with timed show/gap phases
// Optional SEQ_READER_PAUSE_EN adds a pause input that freezes playback in SHOW/GAP.
module seq_reader #(
  parameter int N          = 64,
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int LW         = $clog2(N/4) + 1
) (
  input  logic          CLK,
  input  logic          R,
  input  logic          start,
`ifdef SEQ_READER_PAUSE_EN
  input  logic          pause,
`endif
  input  logic [LW-1:0] len,
  input  logic [N-1:0]  data,
  output logic [3:0]    led,
  output logic [LW-1:0] step,
  output logic          busy,
  output logic          done
);

  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [LW-1:0] MAX_LEN  = LW'(N/4);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [LW-1:0] r_step;
  logic [LW-1:0] r_len;
  logic [N-1:0]  r_data;
  logic [3:0]    r_led;
  logic          r_busy;
  logic          r_done;

  logic [LW-1:0] w_len_clamped;
  logic [LW-1:0] w_step_inc;
  logic [N-1:0]  w_data_next;
  logic          w_hold;

  assign w_len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign w_step_inc    = r_step + LW'(1);
  // The shadow copy shifts left one nibble per step, so the current pattern is always the top nibble.
  assign w_data_next   = r_data << 4;

`ifdef SEQ_READER_PAUSE_EN
  assign w_hold = pause;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_step  <= '0;
      r_len   <= '0;
      r_data  <= '0;
      r_led   <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_step <= '0;
          if (start) begin
            r_data  <= data;
            r_len   <= w_len_clamped;
            r_timer <= '0;
            if (w_len_clamped == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SHOW;
              r_busy  <= 1'b1;
              r_led   <= data[N-1 -: 4];
            end
          end
        end
        S_SHOW: begin
          if (!w_hold) begin
            if (r_timer == ON_LAST) begin
              r_timer <= '0;
              r_led   <= 4'b0000;
              r_state <= S_GAP;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        S_GAP: begin
          if (!w_hold) begin
            if (r_timer == OFF_LAST) begin
              r_timer <= '0;
              if (w_step_inc == r_len) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_SHOW;
                r_step  <= w_step_inc;
                r_data  <= w_data_next;
                r_led   <= w_data_next[N-1 -: 4];
              end
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_led   <= 4'b0000;
          r_step  <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign led  = r_led;
  assign step = r_step;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_seq_reader.sv
// tb/tb_seq_reader.sv - self-checking bench for seq_reader against a cycle-position reference model
module tb_seq_reader;
  localparam int N   = 16;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int LW  = 3;
  localparam int PER = ON + OFF;

  logic          CLK   = 1'b0;
  logic          R     = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [LW-1:0] len   = '0;
  logic [N-1:0]  data  = '0;
  logic [3:0]    led;
  logic [LW-1:0] step;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  seq_reader #(.N(N), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .LW(LW)) dut (
    .CLK   (CLK),
    .R     (R),
    .start (start),
`ifdef SEQ_READER_PAUSE_EN
    .pause (pause),
`endif
    .len   (len),
    .data  (data),
    .led   (led),
    .step  (step),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs at playback position p (1 = first cycle after capture).
  task automatic expect_at(input int p, input logic [15:0] d, input int l, input string ctx);
    int T;
    int k;
    int ph;
    logic [15:0] sh;
    logic [3:0] el;
    T = l * PER;
    if (p >= 1 && p <= T) begin
      k  = (p - 1) / PER;
      ph = (p - 1) % PER;
      sh = d << (4 * k);
      el = (ph < ON) ? sh[15:12] : 4'h0;
      check({ctx, " led"},  {4'h0, led},  {4'h0, el});
      check({ctx, " step"}, {5'h0, step}, 8'(k));
      check({ctx, " busy"}, {7'h0, busy}, 8'h01);
      check({ctx, " done"}, {7'h0, done}, 8'h00);
    end else if (p == T + 1) begin
      check({ctx, " led"},  {4'h0, led},  8'h00);
      check({ctx, " busy"}, {7'h0, busy}, 8'h00);
      check({ctx, " done"}, {7'h0, done}, 8'h01);
    end else begin
      check({ctx, " led"},  {4'h0, led},  8'h00);
      check({ctx, " step"}, {5'h0, step}, 8'h00);
      check({ctx, " busy"}, {7'h0, busy}, 8'h00);
      check({ctx, " done"}, {7'h0, done}, 8'h00);
    end
  endtask

  // pmode: 0 none, 1 pause during cycles 2-6, 2 random pause
  task automatic play(input logic [15:0] d, input int lreq, input bit poke, input int pmode, input string ctx);
    int l;
    int T;
    int p;
    int c;
    l = (lreq > 4) ? 4 : lreq;
    T = l * PER;
    @(posedge CLK); #1;
    data = d; len = lreq[LW-1:0]; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    pause = (pmode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    p = 1;
    c = 1;
    while (p <= T + 3 && c < 400) begin
      @(negedge CLK);
      expect_at(p, d, l, ctx);
      if (!(pause && p >= 1 && p <= T)) p++;
      @(posedge CLK); #1;
      c++;
      start = 1'b0;
      if (poke && c == 7) begin
        start = 1'b1; data = 16'hFFFF; len = 3'd1;
      end
      if (poke && c == T + 1) start = 1'b1;
      case (pmode)
        1:       pause = (c >= 2 && c <= 6);
        2:       pause = ($urandom_range(0, 3) == 0);
        default: pause = 1'b0;
      endcase
    end
    start = 1'b0;
    pause = 1'b0;
    if (c >= 400) check({ctx, " timeout"}, 8'h01, 8'h00);
  endtask

  initial begin
    logic [15:0] rd;
    int rl;
    R = 1'b0;
    #2;
    check("reset led",  {4'h0, led},  8'h00);
    check("reset step", {5'h0, step}, 8'h00);
    check("reset busy", {7'h0, busy}, 8'h00);
    check("reset done", {7'h0, done}, 8'h00);
    @(posedge CLK); #1;
    R = 1'b1;

    play(16'hA5C3, 4, 1'b0, 0, "s1");
    play(16'h1234, 0, 1'b0, 0, "s2 len0");
    play(16'hA5C3, 7, 1'b0, 0, "s3 clamp");
    play(16'hA5C3, 4, 1'b1, 0, "s4 ignore");

    // Reset in the middle of the third SHOW phase.
    @(posedge CLK); #1;
    data = 16'hA5C3; len = 3'd4; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 1; c < 12; c++) begin
      @(negedge CLK);
      expect_at(c, 16'hA5C3, 4, "s5 pre");
      @(posedge CLK); #1;
    end
    R = 1'b0;
    #2;
    check("s5 abort led",  {4'h0, led},  8'h00);
    check("s5 abort busy", {7'h0, busy}, 8'h00);
    check("s5 abort step", {5'h0, step}, 8'h00);
    check("s5 abort done", {7'h0, done}, 8'h00);
    @(posedge CLK); #1;
    R = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("s5 no done", {7'h0, done}, 8'h00);
      check("s5 idle busy", {7'h0, busy}, 8'h00);
    end
    play(16'h5A3C, 2, 1'b0, 0, "s5 restart");

    for (int i = 0; i < 8; i++) begin
      rd = 16'($urandom);
      rl = $urandom_range(0, 7);
      play(rd, rl, 1'b0, 0, "rand");
    end

`ifdef SEQ_READER_PAUSE_EN
    play(16'hA5C3, 4, 1'b0, 1, "s6 pause");
    for (int i = 0; i < 4; i++) begin
      rd = 16'($urandom);
      rl = $urandom_range(1, 4);
      play(rd, rl, 1'b0, 2, "rand pause");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
